load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 23 ++
 rtl/load_store_unit_extend.sv | 27 ++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared control types for the load/store path: load truncation modes,
// LSU FSM states and the default bus timeout.
package HighLevelControl;

  typedef enum logic [2:0] {
    BYTE,
    HALF_WORD,
    WORD,
    BYTE_UNSIGNED,
    HALF_WORD_UNSIGNED,
    NONE
  } truncSrc;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsuState;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/load_store_unit_extend.sv
// Load lane select plus sign/zero extension of a bus read word.
module load_extend
  import HighLevelControl::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  truncSrc     i_trunc,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  // Move the addressed byte lane down to bit 0, then extend per load width.
  always_comb begin
    w_shifted = i_word >> {i_offset, 3'b000};
    o_data    = i_word;
    case (i_trunc)
      BYTE:               o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      HALF_WORD:          o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      WORD:               o_data = w_shifted;
      BYTE_UNSIGNED:      o_data = {24'h000000, w_shifted[7:0]};
      HALF_WORD_UNSIGNED: o_data = {16'h0000, w_shifted[15:0]};
      default:            o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding bus access with alignment check,
// store lane steering, load extension and a REQ+RESP timeout.
module load_store_unit
  import HighLevelControl::*;
#(
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 MemEn,
  input  logic                 MemWrite,
  input  logic [3:0]           ByteEn,
  input  truncSrc              TruncSrc,
  input  logic [WORD_SIZE-1:0] Addr,
  input  logic [WORD_SIZE-1:0] WriteData,
  output logic                 Stall,
  output logic [WORD_SIZE-1:0] ReadData,
  output logic                 MemFault,
  output logic                 BusReq,
  output logic [WORD_SIZE-1:0] BusAddr,
  output logic                 BusWrite,
  output logic [3:0]           BusByteEn,
  output logic [WORD_SIZE-1:0] BusWData,
  input  logic                 BusReady,
  input  logic                 BusRValid,
  input  logic [WORD_SIZE-1:0] BusRData
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  lsuState              r_state;
  lsuState              w_next;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [3:0]           r_byteen;
  logic                 r_write;
  truncSrc              r_trunc;
  logic [CW-1:0]        r_cnt;
  logic                 r_fault;
  logic [WORD_SIZE-1:0] r_rdata;

  logic                 w_misaligned;
  logic                 w_timeout;
  logic                 w_busreq;
  logic                 w_fault_next;
  logic                 w_capture;
  logic                 w_load_done;
  logic [WORD_SIZE-1:0] w_ext;

  load_extend u_extend (
    .i_word  (BusRData),
    .i_offset(r_addr[1:0]),
    .i_trunc (r_trunc),
    .o_data  (w_ext)
  );

  // Alignment check on the live request; stores are judged by lane mask.
  always_comb begin
    w_misaligned = 1'b0;
    if (MemWrite) begin
      w_misaligned = ((ByteEn == 4'b0011) && Addr[0]) ||
                     ((ByteEn == 4'b1111) && (Addr[1:0] != 2'b00));
    end else begin
      w_misaligned = (((TruncSrc == HALF_WORD) || (TruncSrc == HALF_WORD_UNSIGNED)) && Addr[0]) ||
                     ((TruncSrc == WORD) && (Addr[1:0] != 2'b00));
    end
  end

  // Next-state and bus request; the timeout check precedes BusReady/BusRValid.
  always_comb begin
    w_next       = r_state;
    w_busreq     = 1'b0;
    w_fault_next = 1'b0;
    w_capture    = 1'b0;
    w_load_done  = 1'b0;
    w_timeout    = (r_cnt == CW'(TIMEOUT_CYCLES));
    case (r_state)
      IDLE: begin
        if (MemEn) begin
          if (w_misaligned) begin
            w_next       = DONE;
            w_fault_next = 1'b1;
          end else begin
            w_next    = REQ;
            w_capture = 1'b1;
          end
        end
      end
      REQ: begin
        if (w_timeout) begin
          w_next       = DONE;
          w_fault_next = 1'b1;
        end else begin
          w_busreq = 1'b1;
          if (BusReady) w_next = RESP;
        end
      end
      RESP: begin
        if (w_timeout) begin
          w_next       = DONE;
          w_fault_next = 1'b1;
        end else if (BusRValid) begin
          w_next      = DONE;
          w_load_done = !r_write;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, captured request, timeout counter, fault pulse and load result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_byteen <= '0;
      r_write  <= 1'b0;
      r_trunc  <= BYTE;
      r_cnt    <= '0;
      r_fault  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault_next;
      if (w_capture) begin
        r_addr   <= Addr;
        r_wdata  <= WriteData;
        r_byteen <= ByteEn;
        r_write  <= MemWrite;
        r_trunc  <= TruncSrc;
      end
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if ((r_state == REQ) || (r_state == RESP)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fault_next) begin
        r_rdata <= '0;
      end else if (w_load_done) begin
        r_rdata <= w_ext;
      end
    end
  end

  // Bus fields are only driven while requesting, so they read zero otherwise.
  always_comb begin
    Stall     = ((r_state == IDLE) && MemEn) || (r_state == REQ) || (r_state == RESP);
    BusReq    = w_busreq;
    BusAddr   = '0;
    BusWrite  = 1'b0;
    BusByteEn = '0;
    BusWData  = '0;
    if (w_busreq) begin
      BusAddr  = {r_addr[WORD_SIZE-1:2], 2'b00};
      BusWrite = r_write;
      if (r_write) begin
        BusByteEn = r_byteen << r_addr[1:0];
        BusWData  = r_wdata << {r_addr[1:0], 3'b000};
      end else begin
        BusByteEn = 4'b1111;
      end
    end
    ReadData = r_rdata;
    MemFault = r_fault;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven accesses with a
// scoreboard of expected load results/faults, plus reset scenarios.
module tb_load_store_unit;
  import HighLevelControl::*;

  logic        clk;
  logic        reset_n;
  logic        MemEn;
  logic        MemWrite;
  logic [3:0]  ByteEn;
  truncSrc     TruncSrc;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        Stall;
  logic [31:0] ReadData;
  logic        MemFault;
  logic        BusReq;
  logic [31:0] BusAddr;
  logic        BusWrite;
  logic [3:0]  BusByteEn;
  logic [31:0] BusWData;
  logic        BusReady;
  logic        BusRValid;
  logic [31:0] BusRData;

  load_store_unit #(.WORD_SIZE(32), .TIMEOUT_CYCLES(255)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .MemEn    (MemEn),
    .MemWrite (MemWrite),
    .ByteEn   (ByteEn),
    .TruncSrc (TruncSrc),
    .Addr     (Addr),
    .WriteData(WriteData),
    .Stall    (Stall),
    .ReadData (ReadData),
    .MemFault (MemFault),
    .BusReq   (BusReq),
    .BusAddr  (BusAddr),
    .BusWrite (BusWrite),
    .BusByteEn(BusByteEn),
    .BusWData (BusWData),
    .BusReady (BusReady),
    .BusRValid(BusRValid),
    .BusRData (BusRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          wr;
    truncSrc     tr;
    logic [31:0] rd;
    int          rdy;
    int          rv;
    bit          mis;
    bit          tmo;
    logic [31:0] e_rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    bit          fault;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [31:0] last_rdata = 32'h0;
  txn_t        tbl[15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_access(input txn_t t, input int idx);
    exp_t  e;
    exp_t  got_e;
    int    cyc;
    int    breq;
    int    qwait;
    int    rwait;
    int    bad;
    int    exp_lat;
    int    exp_breq;
    bit    in_resp;
    bit    first_req;
    bit    done;
    string p;
    p = $sformatf("t%0d_", idx);
    @(negedge clk);
    MemEn = 1'b1; MemWrite = t.wr; ByteEn = t.be; TruncSrc = t.tr;
    Addr = t.addr; WriteData = t.wd; BusRData = t.rd;
    BusReady = 1'b0; BusRValid = 1'b0;
    if (t.mis || t.tmo) e.rdata = 32'h0;
    else if (t.wr)      e.rdata = last_rdata;
    else                e.rdata = t.e_rdata;
    e.fault    = t.mis || t.tmo;
    last_rdata = e.rdata;
    sb.push_back(e);
    exp_lat  = t.mis ? 2 : (t.tmo ? 258 : 4 + t.rdy + t.rv);
    exp_breq = t.mis ? 0 : (t.tmo ? 255 : t.rdy + 1);
    cyc = 1; breq = 0; qwait = 0; rwait = 0; bad = 0;
    in_resp = 1'b0; first_req = 1'b1; done = 1'b0;
    #1;
    check({p, "stall_issue"}, Stall, 1);
    while (!done && cyc <= 400) begin
      if (!Stall) begin
        done = 1'b1;
      end else begin
        if (in_resp) begin
          BusRValid = (rwait >= t.rv);
          rwait++;
        end else begin
          BusRValid = 1'b0;
        end
        if (BusReq) begin
          breq++;
          if (first_req) begin
            check({p, "bus_addr"}, BusAddr, t.e_addr);
            check({p, "bus_be"}, BusByteEn, t.e_be);
            check({p, "bus_write"}, BusWrite, t.wr);
            if (t.wr) check({p, "bus_wdata"}, BusWData, t.e_wd);
            first_req = 1'b0;
          end
          if (BusAddr !== t.e_addr || BusByteEn !== t.e_be || BusWrite !== t.wr ||
              (t.wr && BusWData !== t.e_wd)) bad++;
          BusReady = (qwait >= t.rdy);
          qwait++;
          if (BusReady) in_resp = 1'b1;
        end else begin
          BusReady = 1'b0;
        end
        @(negedge clk);
        cyc++;
        #1;
      end
    end
    check({p, "done_seen"}, done, 1);
    check({p, "latency"}, cyc, exp_lat);
    check({p, "busreq_cycles"}, breq, exp_breq);
    check({p, "bus_stable"}, bad, 0);
    if (sb.size() == 0) begin
      check({p, "sb_empty"}, 1, 0);
    end else begin
      got_e = sb.pop_front();
      check({p, "readdata"}, ReadData, got_e.rdata);
      check({p, "memfault"}, MemFault, got_e.fault);
    end
    @(negedge clk);
    MemEn = 1'b0; BusReady = 1'b0; BusRValid = 1'b0;
    #1;
    check({p, "fault_pulse_end"}, MemFault, 0);
    check({p, "idle_stall"}, Stall, 0);
  endtask

  task automatic check_zero_outputs(input string p);
    check({p, "busreq"}, BusReq, 0);
    check({p, "buswrite"}, BusWrite, 0);
    check({p, "busbyteen"}, BusByteEn, 0);
    check({p, "busaddr"}, BusAddr, 0);
    check({p, "buswdata"}, BusWData, 0);
    check({p, "readdata"}, ReadData, 0);
    check({p, "memfault"}, MemFault, 0);
  endtask

  initial begin
    //                addr          wd            be       wr    tr                  rd            rdy   rv  mis   tmo   e_rdata       e_addr        e_be     e_wd
    tbl[0]  = '{32'h0000_1003, 32'h0,         4'b0000, 1'b0, BYTE,               32'h80FF_FFFF, 0,    0, 1'b0, 1'b0, 32'hFFFF_FF80, 32'h0000_1000, 4'b1111, 32'h0};
    tbl[1]  = '{32'h0000_0006, 32'h0,         4'b0000, 1'b0, WORD,               32'h1234_5678, 0,    0, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0};
    tbl[2]  = '{32'h0000_0002, 32'h0,         4'b0000, 1'b0, HALF_WORD_UNSIGNED, 32'h8001_0000, 0,    5, 1'b0, 1'b0, 32'h0000_8001, 32'h0000_0000, 4'b1111, 32'h0};
    tbl[3]  = '{32'h0000_2002, 32'h0000_BEEF, 4'b0011, 1'b1, BYTE,               32'h0,         0,    0, 1'b0, 1'b0, 32'h0,         32'h0000_2000, 4'b1100, 32'hBEEF_0000};
    tbl[4]  = '{32'h0000_3001, 32'h0000_00A5, 4'b0001, 1'b1, BYTE,               32'h0,         2,    0, 1'b0, 1'b0, 32'h0,         32'h0000_3000, 4'b0010, 32'h0000_A500};
    tbl[5]  = '{32'h0000_0010, 32'h0,         4'b0000, 1'b0, HALF_WORD,          32'h0000_8765, 0,    0, 1'b0, 1'b0, 32'hFFFF_8765, 32'h0000_0010, 4'b1111, 32'h0};
    tbl[6]  = '{32'h0000_0021, 32'h0,         4'b0000, 1'b0, BYTE_UNSIGNED,      32'h0000_C300, 0,    1, 1'b0, 1'b0, 32'h0000_00C3, 32'h0000_0020, 4'b1111, 32'h0};
    tbl[7]  = '{32'h0000_0040, 32'h0,         4'b0000, 1'b0, WORD,               32'hDEAD_BEEF, 3,    0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0040, 4'b1111, 32'h0};
    tbl[8]  = '{32'h0000_0043, 32'h0,         4'b0000, 1'b0, NONE,               32'h1122_3344, 0,    0, 1'b0, 1'b0, 32'h1122_3344, 32'h0000_0040, 4'b1111, 32'h0};
    tbl[9]  = '{32'h0000_4000, 32'h1234_5678, 4'b1111, 1'b1, WORD,               32'h0,         0,    0, 1'b0, 1'b0, 32'h0,         32'h0000_4000, 4'b1111, 32'h1234_5678};
    tbl[10] = '{32'h0000_2001, 32'h0000_BEEF, 4'b0011, 1'b1, BYTE,               32'h0,         0,    0, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0};
    tbl[11] = '{32'h0000_0005, 32'h0,         4'b0000, 1'b0, HALF_WORD,          32'h0,         0,    0, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0};
    tbl[12] = '{32'h0000_0002, 32'h0,         4'b0000, 1'b0, BYTE,               32'h0044_0000, 0,    2, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0000, 4'b1111, 32'h0};
    tbl[13] = '{32'h0000_4002, 32'h1234_5678, 4'b1111, 1'b1, WORD,               32'h0,         0,    0, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 32'h0};
    tbl[14] = '{32'h0000_0100, 32'h0,         4'b0000, 1'b0, WORD,               32'hAAAA_5555, 1000, 0, 1'b0, 1'b1, 32'h0,         32'h0000_0100, 4'b1111, 32'h0};

    reset_n = 1'b0; MemEn = 1'b0; MemWrite = 1'b0; ByteEn = 4'b0000; TruncSrc = BYTE;
    Addr = 32'h0; WriteData = 32'h0; BusReady = 1'b0; BusRValid = 1'b0; BusRData = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_zero_outputs("rst_");
    check("rst_stall", Stall, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_zero_outputs("post_rst_");

    // Loaded the previous load result before the misaligned LW, so its
    // zeroing of ReadData is observable.
    for (int i = 0; i < 15; i++) begin
      do_access(tbl[i], i);
    end

    // A late bus response after the timeout must leave the unit idle.
    @(negedge clk);
    BusRValid = 1'b1; BusReady = 1'b1; BusRData = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("late_rvalid%0d_stall", k), Stall, 0);
      check($sformatf("late_rvalid%0d_busreq", k), BusReq, 0);
      check($sformatf("late_rvalid%0d_rdata", k), ReadData, 0);
      check($sformatf("late_rvalid%0d_fault", k), MemFault, 0);
    end
    BusRValid = 1'b0; BusReady = 1'b0;

    // Prime ReadData, then reset in the middle of a load's RESP phase.
    do_access(tbl[7], 100);
    @(negedge clk);
    MemEn = 1'b1; MemWrite = 1'b0; TruncSrc = WORD; Addr = 32'h0000_0050; BusRData = 32'h0BAD_F00D;
    @(negedge clk);
    #1;
    check("mid_req", BusReq, 1);
    BusReady = 1'b1;
    @(negedge clk);
    #1;
    BusReady = 1'b0;
    check("mid_resp_busreq", BusReq, 0);
    check("mid_resp_stall", Stall, 1);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_resp_busreq", BusReq, 0);
    check("rst_resp_stall_memen1", Stall, 1);
    check("rst_resp_readdata", ReadData, 0);
    check("rst_resp_busaddr", BusAddr, 0);
    MemEn = 1'b0;
    #1;
    check("rst_resp_stall_memen0", Stall, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_zero_outputs("post_rst2_");
    last_rdata = 32'h0;

    // Recovery after the mid-transaction reset.
    do_access(tbl[0], 200);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
